wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a long-latency unit (LU, e.g. mul/div).
- Pipeline writeback always has priority. LU results are buffered in a small in-order FIFO and drained on idle write-port cycles.
- A starvation counter raises a stall request so the hazard unit can inject a writeback bubble.
- Exports a RAW-hazard flag for decode-stage source registers that match queued results.

Parameters:
- DATA_WIDTH, 32, register data width
- FIFO_DEPTH, 2, LU result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may wait before stall_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- reg_write_w  in  1  pipeline writeback enable
- rd_w  in  5  pipeline destination register
- result_w  in  DATA_WIDTH  pipeline writeback data
- lu_valid  in  1  LU result available
- lu_rd  in  5  LU destination register
- lu_data  in  DATA_WIDTH  LU result data
- lu_ready  out  1  arbiter accepts LU result this cycle
- rs1_d  in  5  decode source 1
- rs2_d  in  5  decode source 2
- raw_hazard  out  1  rs1_d/rs2_d (non-zero) matches a valid queued entry
- stall_req  out  1  request to hazard unit: freeze pipeline, bubble into W
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wd  out  DATA_WIDTH  register-file write data

Behaviour:
- Reset:
  - FIFO empty, all entry valid bits 0.
  - Starve counter 0, stall_req 0.
  - Combinational outputs follow from the empty state: lu_ready=1, rf_we=0 when reg_write_w=0, raw_hazard=0.
- Pipeline write condition: pw = reg_write_w && rd_w!=0.
- Write port (combinational, zero latency):
  - pw=1: rf_we=1, rf_rd=rd_w, rf_wd=result_w.
  - Else if FIFO head valid: rf_we=1 with head rd/data; head pops at the clock edge.
  - Else rf_we=0; rf_rd and rf_wd are 0.
- LU handshake:
  - lu_ready = !full || pop_this_cycle.
  - Transfer occurs when lu_valid && lu_ready.
  - lu_rd==0 transfers are accepted and discarded, not enqueued.
  - The LU must hold lu_valid, lu_rd and lu_data stable until accepted.
- Empty-FIFO LU result: it is enqueued and written on the next cycle at the earliest. There is no same-cycle bypass to the write port.
- Simultaneous push and pop: legal when full. Occupancy is unchanged and pointers advance with wrap-around modulo FIFO_DEPTH.
- WAW kill:
  - Precondition: LU latency ≥2 cycles, so any coinciding pipeline write is younger.
  - When pw=1, every valid queued entry with rd == rd_w is invalidated at that edge.
  - Invalid entries still occupy their slot. When an invalid entry reaches the head it pops without asserting rf_we and consumes a drain cycle.
  - An LU result accepted in the same cycle with lu_rd == rd_w is enqueued valid, because it is newer than the pipeline write.
- Starvation:
  - The counter increments each cycle in which the FIFO is non-empty and pw=1, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - stall_req is registered: it asserts the cycle after the counter reaches STARVE_LIMIT and stays high until the next pop.
  - The hazard unit guarantees reg_write_w=0 while stall_req=1.
- raw_hazard: combinational OR over valid entries of (rd==rs1_d && rs1_d!=0) || (rd==rs2_d && rs2_d!=0).
- Reset mid-operation: asynchronous clear of the FIFO, counter and stall_req. Queued results are lost; the pipeline is flushed by the same reset.

Decomposition:
- Shared package (riscv_pkg):
  - REG_ADDR_W=5
  - the x0 constant
  - typedef wb_req_t {we, rd, data}
- Sub-module wb_result_fifo: parameterised sync FIFO with per-entry valid bits, a kill-by-rd port and compare outputs per entry. The arbiter holds the mux, counter and handshake logic.

Test Plan:
- Pipeline only: reg_write_w=1, rd_w=3, result_w=0xAA, lu_valid=0 → same cycle rf_we=1, rf_rd=3, rf_wd=0xAA; lu_ready=1, stall_req=0.
- Idle drain: lu_valid=1, lu_rd=7, lu_data=0x1234 for one cycle, pipeline idle → next cycle rf_we=1, rf_rd=7, rf_wd=0x1234; FIFO empty after.
- Full/backpressure: pipeline writes every cycle and the LU offers 3 results → first two accepted, lu_ready=0 on the third. The third is accepted on the first pop cycle.
- Starvation: FIFO holds 1 entry and pw=1 continuously → stall_req rises STARVE_LIMIT+1=5 cycles after enqueue. Driving reg_write_w=0 then drains the entry and stall_req falls the next cycle.
- WAW kill: queue rd=9 data=0x55, then pipeline writes rd=9 data=0x66 → later idle cycles produce no write to r9; raw_hazard for rs1_d=9 drops after the kill.
- x0 and reset: LU result with lu_rd=0 is never written. Asserting rst with 2 queued entries → rf_we=0, lu_ready=1, raw_hazard=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file definitions: address width, the hard-wired zero register
// and the write-port request bundle.
package riscv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// In-order result buffer with per-entry valid bits, a kill-by-destination port
// and per-entry source-register compare outputs for hazard detection.
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [REG_ADDR_W-1:0] i_push_rd,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [REG_ADDR_W-1:0] i_kill_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_head_vld,
  output logic [REG_ADDR_W-1:0] o_head_rd,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [DEPTH-1:0]      o_match_rs1,
  output logic [DEPTH-1:0]      o_match_rs2
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [DEPTH-1:0]      r_vld;
  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Later assignments win: a fresh push into a slot overrides pop-clear and kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_rd[i] == i_kill_rd) r_vld[i] <= 1'b0;
      if (i_pop)  r_vld[r_rptr] <= 1'b0;
      if (i_push) r_vld[r_wptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_wptr]   <= i_push_rd;
      r_data[r_wptr] <= i_push_data;
    end
  end

  always_comb begin
    o_match_rs1 = '0;
    o_match_rs2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match_rs1[i] = r_vld[i] && (i_rs1 != X0) && (r_rd[i] == i_rs1);
      o_match_rs2[i] = r_vld[i] && (i_rs2 != X0) && (r_rd[i] == i_rs2);
    end
  end

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_head_vld  = !o_empty && r_vld[r_rptr];
  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results
// are queued and drained on idle cycles, with starvation stall and RAW flag.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_w,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic [DATA_WIDTH-1:0] result_w,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  output logic                  raw_hazard,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wd
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic                  w_pw;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_head_vld;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [FIFO_DEPTH-1:0] w_match_rs1;
  logic [FIFO_DEPTH-1:0] w_match_rs2;
  wb_req_t               w_req;

  logic [SC_W-1:0]       r_starve;
  logic                  r_stall;

  // The head drains whenever the pipeline leaves the port idle; killed entries
  // still pop and burn the cycle without a write.
  assign w_pw     = reg_write_w && (rd_w != X0);
  assign w_pop    = !w_pw && !w_empty;
  assign lu_ready = !w_full || w_pop;
  assign w_push   = lu_valid && lu_ready && (lu_rd != X0);

  wb_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (lu_rd),
    .i_push_data (lu_data),
    .i_pop       (w_pop),
    .i_kill      (w_pw),
    .i_kill_rd   (rd_w),
    .i_rs1       (rs1_d),
    .i_rs2       (rs2_d),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_head_vld  (w_head_vld),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_match_rs1 (w_match_rs1),
    .o_match_rs2 (w_match_rs2)
  );

  always_comb begin
    w_req = '0;
    if (w_pw) begin
      w_req.we   = 1'b1;
      w_req.rd   = rd_w;
      w_req.data = result_w;
    end else if (w_pop && w_head_vld) begin
      w_req.we   = 1'b1;
      w_req.rd   = w_head_rd;
      w_req.data = w_head_data;
    end
  end

  assign rf_we      = w_req.we;
  assign rf_rd      = w_req.rd;
  assign rf_wd      = w_req.data;
  assign raw_hazard = |{w_match_rs1, w_match_rs2};

  // Counter saturates at the limit; the stall request is raised one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else if (r_starve == SC_W'(STARVE_LIMIT)) begin
      r_stall  <= 1'b1;
    end else if (w_pw) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign stall_req = r_stall;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios followed by random traffic checked against a queue-based
// model of the write-port arbiter.
module tb_wb_port_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          reg_write_w;
  logic [4:0]    rd_w;
  logic [DW-1:0] result_w;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic [4:0]    rs1_d;
  logic [4:0]    rs2_d;
  logic          raw_hazard;
  logic          stall_req;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wd;

  int n_err;
  int n_checks;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] d;
    bit            v;
  } ent_t;

  ent_t q[$];

  wb_port_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .result_w    (result_w),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .raw_hazard  (raw_hazard),
    .stall_req   (stall_req),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit            pend;
    bit            m_stall;
    int            m_wait;
    bit            e_pw, e_pop, e_we, e_ready, e_raw, acc, was_empty;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_wd;
    ent_t          tmp;

    n_err = 0; n_checks = 0;
    rst = 1'b1; reg_write_w = 0; rd_w = 0; result_w = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0; rs1_d = 0; rs2_d = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_we", rf_we, 0);
    check("rst_ready", lu_ready, 1);
    check("rst_raw", raw_hazard, 0);
    check("rst_stall", stall_req, 0);
    rst = 1'b0;

    // pipeline only
    @(negedge clk); reg_write_w = 1; rd_w = 3; result_w = 32'hAA; #1;
    check("pipe_we", rf_we, 1);
    check("pipe_rd", rf_rd, 3);
    check("pipe_wd", rf_wd, 32'hAA);
    check("pipe_ready", lu_ready, 1);
    check("pipe_stall", stall_req, 0);

    // idle drain, no same-cycle bypass
    @(negedge clk); reg_write_w = 0; lu_valid = 1; lu_rd = 7; lu_data = 32'h1234; rs1_d = 7; #1;
    check("drain_nobypass", rf_we, 0);
    check("drain_ready", lu_ready, 1);
    @(negedge clk); lu_valid = 0; #1;
    check("drain_we", rf_we, 1);
    check("drain_rd", rf_rd, 7);
    check("drain_wd", rf_wd, 32'h1234);
    check("drain_raw", raw_hazard, 1);
    @(negedge clk); #1;
    check("drain_empty_we", rf_we, 0);
    check("drain_empty_raw", raw_hazard, 0);
    rs1_d = 0;

    // full / backpressure
    @(negedge clk); reg_write_w = 1; rd_w = 1; result_w = 1; lu_valid = 1; lu_rd = 10; lu_data = 32'hA0; #1;
    check("bp_ready0", lu_ready, 1);
    @(negedge clk); lu_rd = 11; lu_data = 32'hB0; #1;
    check("bp_ready1", lu_ready, 1);
    check("bp_prio_rd", rf_rd, 1);
    @(negedge clk); lu_rd = 12; lu_data = 32'hC0; #1;
    check("bp_full_ready", lu_ready, 0);
    @(negedge clk); #1;
    check("bp_hold_ready", lu_ready, 0);
    @(negedge clk); reg_write_w = 0; #1;
    check("bp_pop_ready", lu_ready, 1);
    check("bp_pop_rd", rf_rd, 10);
    check("bp_pop_wd", rf_wd, 32'hA0);
    check("bp_stall", stall_req, 0);
    @(negedge clk); lu_valid = 0; #1;
    check("bp_pop2_rd", rf_rd, 11);
    check("bp_pop2_wd", rf_wd, 32'hB0);
    @(negedge clk); #1;
    check("bp_pop3_rd", rf_rd, 12);
    check("bp_pop3_wd", rf_wd, 32'hC0);
    @(negedge clk); #1;
    check("bp_done_we", rf_we, 0);

    // starvation
    @(negedge clk); reg_write_w = 1; rd_w = 2; lu_valid = 1; lu_rd = 13; lu_data = 32'hD; #1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); lu_valid = 0; #1;
      check($sformatf("starve_low%0d", i), stall_req, 0);
    end
    @(negedge clk); reg_write_w = 0; #1;
    check("starve_high", stall_req, 1);
    check("starve_drain_rd", rf_rd, 13);
    check("starve_drain_wd", rf_wd, 32'hD);
    @(negedge clk); #1;
    check("starve_fall", stall_req, 0);
    check("starve_idle_we", rf_we, 0);

    // WAW kill
    @(negedge clk); reg_write_w = 1; rd_w = 4; lu_valid = 1; lu_rd = 9; lu_data = 32'h55; rs1_d = 9; #1;
    check("waw_raw_pre", raw_hazard, 0);
    @(negedge clk); lu_valid = 0; #1;
    check("waw_raw_q", raw_hazard, 1);
    @(negedge clk); rd_w = 9; result_w = 32'h66; #1;
    check("waw_pw_rd", rf_rd, 9);
    check("waw_pw_wd", rf_wd, 32'h66);
    check("waw_raw_edge", raw_hazard, 1);
    @(negedge clk); reg_write_w = 0; #1;
    check("waw_killed_we", rf_we, 0);
    check("waw_killed_raw", raw_hazard, 0);
    @(negedge clk); #1;
    check("waw_after_we", rf_we, 0);
    check("waw_after_ready", lu_ready, 1);
    rs1_d = 0;

    // same-cycle LU result is newer than the pipeline write
    @(negedge clk); reg_write_w = 1; rd_w = 8; result_w = 32'h11; lu_valid = 1; lu_rd = 8; lu_data = 32'h77; #1;
    @(negedge clk); reg_write_w = 0; lu_valid = 0; #1;
    check("newer_we", rf_we, 1);
    check("newer_rd", rf_rd, 8);
    check("newer_wd", rf_wd, 32'h77);

    // x0 results are never written
    @(negedge clk); lu_valid = 1; lu_rd = 0; lu_data = 32'hFF; #1;
    check("x0_ready", lu_ready, 1);
    check("x0_we0", rf_we, 0);
    @(negedge clk); lu_valid = 0; #1;
    check("x0_we1", rf_we, 0);
    @(negedge clk); reg_write_w = 1; rd_w = 0; result_w = 32'h5; #1;
    check("x0_pipe_we", rf_we, 0);

    // asynchronous reset with two queued entries
    @(negedge clk); rd_w = 5; lu_valid = 1; lu_rd = 20; lu_data = 32'h20; #1;
    @(negedge clk); lu_rd = 21; lu_data = 32'h21; #1;
    @(negedge clk); lu_valid = 0; rs1_d = 20; rs2_d = 21; #1;
    check("arst_pre_raw", raw_hazard, 1);
    check("arst_pre_ready", lu_ready, 0);
    #1; rst = 1'b1; reg_write_w = 0; #1;
    check("arst_we", rf_we, 0);
    check("arst_ready", lu_ready, 1);
    check("arst_raw", raw_hazard, 0);
    check("arst_stall", stall_req, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("arst_lost_we", rf_we, 0);
    rs1_d = 0; rs2_d = 0;

    // random traffic against the queue model
    q.delete(); pend = 0; m_stall = 0; m_wait = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1; lu_rd = 5'($urandom_range(0, 7)); lu_data = $urandom;
      end
      lu_valid = pend;
      rs1_d = 5'($urandom_range(0, 7));
      rs2_d = 5'($urandom_range(0, 7));
      rd_w = 5'($urandom_range(0, 7));
      result_w = $urandom;
      reg_write_w = m_stall ? 1'b0 : ($urandom_range(0, 99) < ((c < 300) ? 85 : 35));
      #1;
      e_pw    = reg_write_w && (rd_w != 0);
      e_pop   = !e_pw && (q.size() != 0);
      e_we    = 0; e_rd = 0; e_wd = 0;
      if (e_pw) begin
        e_we = 1; e_rd = rd_w; e_wd = result_w;
      end else if (e_pop && q[0].v) begin
        e_we = 1; e_rd = q[0].rd; e_wd = q[0].d;
      end
      e_ready = (q.size() < DEPTH) || e_pop;
      e_raw = 0;
      foreach (q[i])
        if (q[i].v && ((rs1_d != 0 && q[i].rd == rs1_d) || (rs2_d != 0 && q[i].rd == rs2_d)))
          e_raw = 1;
      check("rnd_we", rf_we, e_we);
      check("rnd_rd", rf_rd, e_rd);
      check("rnd_wd", rf_wd, e_wd);
      check("rnd_ready", lu_ready, e_ready);
      check("rnd_raw", raw_hazard, e_raw);
      check("rnd_stall", stall_req, m_stall);

      was_empty = (q.size() == 0);
      acc = lu_valid && e_ready;
      if (e_pop) tmp = q.pop_front();
      if (e_pw) foreach (q[i]) if (q[i].rd == rd_w) q[i].v = 0;
      if (acc && lu_rd != 0) q.push_back('{rd: lu_rd, d: lu_data, v: 1'b1});
      if (acc) pend = 0;
      if (e_pop || was_empty) begin
        m_wait = 0; m_stall = 0;
      end else if (m_wait == LIMIT) begin
        m_stall = 1;
      end else if (e_pw) begin
        m_wait++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
